// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch sequencer, branch adder and instruction memory.
package pc_sequencer_pkg;

  localparam int PC_W_DEFAULT     = 10;
  localparam int RESET_PC_DEFAULT = 0;

  typedef enum logic [2:0] {
    RST_HOLD   = 3'd0,
    FETCH      = 3'd1,
    SQUASH     = 3'd2,
    HALT_DRAIN = 3'd3,
    HALTED     = 3'd4
  } seq_state_e;

endpackage

// File: rtl/pc_sequencer.sv
// Program-counter owner: issues req/ack instruction fetches, delivers instructions
// to decode, and redirects fetch on taken branches, dropping wrong-path data.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int              N        = PC_W_DEFAULT,
  parameter logic [N-1:0]    RESET_PC = N'(RESET_PC_DEFAULT)
) (
  input  logic         clk,
  input  logic         rst,
  output logic [N-1:0] pcPlusOne,
  input  logic [N-1:0] branchTarget,
  input  logic         branchTaken,
  input  logic         haltReq,
  output logic         imemReq,
  output logic [N-1:0] imemAddr,
  input  logic         imemAck,
  output logic         instrValid,
  output logic [N-1:0] pcCurrent,
  output logic         halted
);

  seq_state_e   state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic [N-1:0] pc_cur_q, pc_cur_d;
  logic [N-1:0] redirect_pc_q, redirect_pc_d;
  logic         vld_q, vld_d;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pc_cur_d      = pc_cur_q;
    redirect_pc_d = redirect_pc_q;
    vld_d         = 1'b0;
    unique case (state_q)
      RST_HOLD: state_d = FETCH;
      FETCH: begin
        // A delivered halt/branch makes the fetch currently in flight wrong-path.
        if (vld_q && haltReq) begin
          state_d = imemAck ? HALTED : HALT_DRAIN;
        end else if (vld_q && branchTaken) begin
          if (imemAck) begin
            pc_d = branchTarget;
          end else begin
            redirect_pc_d = branchTarget;
            state_d       = SQUASH;
          end
        end else if (imemAck) begin
          vld_d    = 1'b1;
          pc_cur_d = pc_q;
          pc_d     = pc_q + N'(1);
        end
      end
      SQUASH: begin
        if (imemAck) begin
          pc_d    = redirect_pc_q;
          state_d = FETCH;
        end
      end
      HALT_DRAIN: if (imemAck) state_d = HALTED;
      HALTED:     state_d = HALTED;
      default:    state_d = RST_HOLD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RST_HOLD;
      pc_q          <= RESET_PC;
      pc_cur_q      <= RESET_PC;
      redirect_pc_q <= '0;
      vld_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pc_cur_q      <= pc_cur_d;
      redirect_pc_q <= redirect_pc_d;
      vld_q         <= vld_d;
    end
  end

  // pc_q only advances on an ack, so it is the outstanding address in every requesting state.
  assign imemReq    = (state_q == FETCH) || (state_q == SQUASH) || (state_q == HALT_DRAIN);
  assign imemAddr   = pc_q;
  assign instrValid = vld_q;
  assign pcCurrent  = pc_cur_q;
  assign pcPlusOne  = pc_cur_q + N'(1);
  assign halted     = (state_q == HALTED);

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomised and directed bench for pc_sequencer: two instances (reset PC 0 and 1022)
// share stimulus and are compared each cycle against a transaction-level model.
module tb_pc_sequencer;

  logic       clk;
  logic       rst;
  logic [9:0] branch_target;
  logic       branch_taken;
  logic       halt_req;
  logic       imem_ack;

  logic [9:0] pc_plus_one [2];
  logic       imem_req    [2];
  logic [9:0] imem_addr   [2];
  logic       instr_valid [2];
  logic [9:0] pc_current  [2];
  logic       halted_o    [2];

  int n_checks = 0;
  int n_errors = 0;

  // Model: what each instance is asking memory for, and what it owes decode.
  logic [9:0] rst_pc    [2];
  logic [9:0] m_addr    [2];
  logic [9:0] m_cur     [2];
  logic [9:0] m_redir   [2];
  bit         m_req     [2];
  bit         m_vld     [2];
  bit         m_startup [2];
  bit         m_halted  [2];
  bit         m_drain   [2];
  bit         m_pend    [2];

  pc_sequencer #(.N(10), .RESET_PC(10'd0)) u_dut0 (
    .clk(clk), .rst(rst), .pcPlusOne(pc_plus_one[0]), .branchTarget(branch_target),
    .branchTaken(branch_taken), .haltReq(halt_req), .imemReq(imem_req[0]),
    .imemAddr(imem_addr[0]), .imemAck(imem_ack), .instrValid(instr_valid[0]),
    .pcCurrent(pc_current[0]), .halted(halted_o[0])
  );

  pc_sequencer #(.N(10), .RESET_PC(10'd1022)) u_dut1 (
    .clk(clk), .rst(rst), .pcPlusOne(pc_plus_one[1]), .branchTarget(branch_target),
    .branchTaken(branch_taken), .haltReq(halt_req), .imemReq(imem_req[1]),
    .imemAddr(imem_addr[1]), .imemAck(imem_ack), .instrValid(instr_valid[1]),
    .pcCurrent(pc_current[1]), .halted(halted_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_addr[k] = rst_pc[k];  m_cur[k] = rst_pc[k];  m_redir[k] = '0;
      m_req[k] = 0;  m_vld[k] = 0;  m_startup[k] = 1;
      m_halted[k] = 0;  m_drain[k] = 0;  m_pend[k] = 0;
    end
  endtask

  task automatic model_advance(input int k, input bit ack, input bit br, input bit hl,
                               input logic [9:0] tgt);
    bit ack_eff = ack && m_req[k];
    bit dec     = m_vld[k];
    m_vld[k] = 0;
    if (m_halted[k]) begin
      m_req[k] = 0;
    end else if (m_startup[k]) begin
      m_startup[k] = 0;
      m_req[k]     = 1;
    end else if (dec && hl) begin
      if (ack_eff) begin m_halted[k] = 1; m_req[k] = 0; end
      else m_drain[k] = 1;
    end else if (dec && br) begin
      if (ack_eff) m_addr[k] = tgt;
      else begin m_pend[k] = 1; m_redir[k] = tgt; end
    end else if (ack_eff) begin
      if (m_drain[k]) begin
        m_drain[k] = 0; m_halted[k] = 1; m_req[k] = 0;
      end else if (m_pend[k]) begin
        m_pend[k] = 0; m_addr[k] = m_redir[k];
      end else begin
        m_vld[k]  = 1;
        m_cur[k]  = m_addr[k];
        m_addr[k] = m_addr[k] + 10'd1;
      end
    end
  endtask

  task automatic check_model();
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("req%0d", k), imem_req[k], m_req[k]);
      check_eq($sformatf("vld%0d", k), instr_valid[k], m_vld[k]);
      check_eq($sformatf("halted%0d", k), halted_o[k], m_halted[k]);
      check_eq($sformatf("pccur%0d", k), pc_current[k], m_cur[k]);
      check_eq($sformatf("pcp1_%0d", k), pc_plus_one[k], 32'(10'(m_cur[k] + 10'd1)));
      if (m_req[k]) check_eq($sformatf("addr%0d", k), imem_addr[k], m_addr[k]);
    end
  endtask

  // Called at a falling edge: check, drive this cycle's inputs, advance model, next falling edge.
  task automatic step(input bit ack, input bit br, input bit hl, input logic [9:0] tgt);
    check_model();
    imem_ack = ack;  branch_taken = br;  halt_req = hl;  branch_target = tgt;
    for (int k = 0; k < 2; k++) model_advance(k, ack, br, hl, tgt);
    @(negedge clk);
  endtask

  task automatic do_reset();
    imem_ack = 1'b1;  branch_taken = 1'b0;  halt_req = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("rst_req0", imem_req[0], 0);
    check_eq("rst_vld0", instr_valid[0], 0);
    check_eq("rst_halted0", halted_o[0], 0);
    check_eq("rst_pccur0", pc_current[0], 0);
    check_eq("rst_pccur1", pc_current[1], 1022);
    check_eq("rst_pcp1_1", pc_plus_one[1], 1023);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic run_to(input logic [9:0] target);
    bit found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (m_vld[0] && m_cur[0] == target) found = 1;
      else step(1, 0, 0, 10'd0);
    end
    check_eq("reach_pc", found, 1);
  endtask

  initial begin
    rst = 1'b1;  imem_ack = 1'b0;  branch_taken = 1'b0;  halt_req = 1'b0;
    branch_target = '0;
    rst_pc[0] = 10'd0;  rst_pc[1] = 10'd1022;
    @(negedge clk);
    do_reset();

    // Ack every cycle: delivery stream and wrap on the 1022 instance.
    check_eq("hold_req0", imem_req[0], 0);
    step(1, 0, 0, 10'd0);
    check_eq("first_req0", imem_req[0], 1);
    step(1, 0, 0, 10'd0);
    for (int i = 0; i < 4; i++) begin
      check_eq("seq_vld0", instr_valid[0], 1);
      check_eq("seq_pccur0", pc_current[0], i);
      check_eq("seq_pcp1_0", pc_plus_one[0], i + 1);
      check_eq("wrap_pccur1", pc_current[1], (1022 + i) % 1024);
      step(1, 0, 0, 10'd0);
    end

    // Taken branch with the wrong-path ack in the same cycle.
    run_to(10'd5);
    step(1, 1, 0, 10'd3);
    check_eq("br_ack_vld0", instr_valid[0], 0);
    check_eq("br_ack_addr0", imem_addr[0], 3);
    step(1, 0, 0, 10'd0);
    check_eq("br_ack_next_pc0", pc_current[0], 3);

    // Taken branch while the request is stalled.
    run_to(10'd5);
    step(0, 1, 0, 10'd20);
    check_eq("sq_addr_a", imem_addr[0], 6);
    step(0, 0, 0, 10'd0);
    check_eq("sq_addr_b", imem_addr[0], 6);
    step(0, 0, 0, 10'd0);
    check_eq("sq_addr_c", imem_addr[0], 6);
    step(1, 0, 0, 10'd0);
    check_eq("sq_drop_vld0", instr_valid[0], 0);
    check_eq("sq_redir_addr0", imem_addr[0], 20);
    step(1, 0, 0, 10'd0);
    check_eq("sq_next_pc0", pc_current[0], 20);

    // Halt beats branch, drain while ack is withheld.
    do_reset();
    run_to(10'd8);
    step(0, 1, 1, 10'd100);
    step(0, 0, 0, 10'd0);
    check_eq("drain_req0", imem_req[0], 1);
    check_eq("drain_halted0", halted_o[0], 0);
    step(1, 0, 0, 10'd0);
    check_eq("halt_halted0", halted_o[0], 1);
    check_eq("halt_req0", imem_req[0], 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 10'd7);
    check_eq("halt_sticky0", halted_o[0], 1);

    // Async reset in the middle of a squash with the ack arriving.
    do_reset();
    run_to(10'd5);
    step(0, 1, 0, 10'd40);
    step(0, 0, 0, 10'd0);
    do_reset();
    step(1, 0, 0, 10'd0);
    check_eq("restart_addr0", imem_addr[0], 0);
    step(1, 0, 0, 10'd0);
    check_eq("restart_pc0", pc_current[0], 0);

    // Random traffic, including branch/halt strobes while nothing is delivered.
    for (int c = 0; c < 3000; c++) begin
      if ((m_halted[0] && m_halted[1]) || $urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step(($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 39) == 0), 10'($urandom));
      end
    end
    check_model();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Producer/consumer at the far end of the branch-target path: owns the program counter and issues instruction fetches to instruction memory over a req/ack handshake.
- Exports the PC+1 of the delivered instruction to the branch adder.
- Accepts the computed branch target back from the adder and redirects fetch, squashing any wrong-path fetch already in flight.
- Sits between instruction memory and decode.

Parameters:
- N, 10, PC / instruction-address width; all PC arithmetic is modulo 2^N.
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- pcPlusOne  out  N  pcCurrent+1, combinational from the pcCurrent register; feeds the branch adder.
- branchTarget  in  N  branch target from the branch adder; sampled only with branchTaken.
- branchTaken  in  1  decode says the delivered instruction branches; valid only while instrValid=1.
- haltReq  in  1  decode says the delivered instruction is HALT; valid only while instrValid=1.
- imemReq  out  1  fetch request to instruction memory.
- imemAddr  out  N  fetch address; stable while imemReq=1 until imemAck.
- imemAck  in  1  memory completes the current request this cycle; ignored when imemReq=0.
- instrValid  out  1  one-cycle pulse per delivered instruction (registered).
- pcCurrent  out  N  address of the instruction delivered with instrValid.
- halted  out  1  high once the machine is halted; sticky until rst.

Behaviour:
- Reset (async, any state, including mid-request) forces the following, all immediately:
  - state = RST_HOLD, pc = RESET_PC, pcCurrent = RESET_PC.
  - imemReq = 0, instrValid = 0, halted = 0, squash/redirect registers cleared.
- Any imemAck arriving while rst=1 is dropped.
- States and transitions:
  - RST_HOLD: imemReq=0 for exactly one cycle after rst deasserts, then go to FETCH.
  - FETCH: imemReq=1, imemAddr=pc.
    - On imemAck: next cycle instrValid=1, pcCurrent=pc, pc=pc+1. imemReq stays high, so back-to-back ack gives 1 instruction/cycle.
  - SQUASH: imemReq=1 on the old (wrong-path) address, held stable.
    - On imemAck: discard the data (no instrValid), set pc=redirectPc, go to FETCH.
  - HALT_DRAIN: imemReq=1 on the outstanding address.
    - On imemAck: discard the data, go to HALTED.
  - HALTED: imemReq=0, halted=1. Leave only via rst.
- Redirect: when instrValid=1 and branchTaken=1 (no haltReq):
  - If imemAck is also high this cycle: the acked fetch is wrong-path. Next cycle instrValid=0, pc=branchTarget, state stays FETCH, and imemAddr=branchTarget.
  - If imemAck is low: capture redirectPc=branchTarget and go to SQUASH. imemAddr must not change mid-request.
- Halt: when instrValid=1 and haltReq=1, haltReq takes priority over branchTaken.
  - If imemAck is high this cycle: discard and go straight to HALTED.
  - Otherwise go to HALT_DRAIN.
- branchTaken and haltReq are ignored when instrValid=0.
- Latency: ack at cycle t -> instrValid at t+1. Taken branch at t+1 -> target address on imemAddr at t+2 at the earliest.
- pc and pcPlusOne wrap from 2^N-1 to 0 with no flag. The branch target is used verbatim, with no width checks.
- instrValid is never high in two consecutive cycles unless there are two separate acks.

Decomposition:
- Shared package:
  - state enum {RST_HOLD, FETCH, SQUASH, HALT_DRAIN, HALTED}.
  - Default N=10 and RESET_PC constants, shared with the branch adder and the instruction memory.
- No sub-module needed: one FSM, the pc/pcCurrent/redirectPc registers, and an inline incrementer.

Test Plan:
- Reset, then imemAck held high every cycle -> imemReq rises 1 cycle after rst release; instrValid pulses with pcCurrent=0,1,2,3 on consecutive cycles; pcPlusOne=1,2,3,4.
- Branch with ack same cycle:
  - Stimulus: at pcCurrent=5, branchTaken=1, branchTarget=3 (bench adder 6+(-3)), imemAck=1.
  - Required: next cycle instrValid=0 and imemAddr=3; the following delivery has pcCurrent=3.
- Branch during stalled request:
  - Stimulus: ack withheld; branchTaken at pcCurrent=5 with target 20; ack arrives 3 cycles later.
  - Required: imemAddr stays 6 until the ack; that data is discarded; next imemAddr=20; the next delivered pcCurrent=20.
- Wrap: RESET_PC=1022, ack every cycle -> pcCurrent sequence 1022, 1023, 0, 1.
- Halt vs branch: haltReq=1 and branchTaken=1 together on pcCurrent=8, ack withheld 2 cycles -> state HALT_DRAIN, no further instrValid, halted=1 after the ack, imemReq=0 thereafter.
- Async reset mid-SQUASH with ack pending -> all outputs at reset values in the same cycle; the ack is ignored; fetch restarts at RESET_PC.
